// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - hazard detection and forwarding controller for the in-order pipeline
module hazard_scoreboard #(
    parameter int RW       = 5,
    parameter int NSTG     = 2,
    parameter int LOAD_LAT = 1,
    parameter int BR_STG   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [RW-1:0]               id_rs,
    input  logic [RW-1:0]               id_rt,
    input  logic [RW-1:0]               id_rd,
    input  logic                        id_use_rs,
    input  logic                        id_use_rt,
    input  logic                        id_wr,
    input  logic                        id_load,
    input  logic                        id_jump,
    input  logic                        br_taken,
    input  logic                        mem_wait,
    output logic                        stall,
    output logic                        freeze,
    output logic                        flush_if_id,
    output logic                        flush_front,
    output logic [$clog2(NSTG+1)-1:0]   fwd_a,
    output logic [$clog2(NSTG+1)-1:0]   fwd_b,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam int FW = $clog2(NSTG + 1);

    // Scoreboard entries at positions 0..NSTG-1. The entry that would sit at
    // position NSTG is never matched (it retires on the next edge and the
    // register file is write-through), so it needs no storage.
    logic [NSTG-1:0] e_valid;
    logic [NSTG-1:0] e_wr;
    logic [NSTG-1:0] e_load;
    logic [RW-1:0]   e_rd [NSTG];

    // Per-operand lookup results
    logic [FW-1:0]   src_a;
    logic [FW-1:0]   src_b;
    logic            haz_a;
    logic            haz_b;
    logic            en_a;
    logic            en_b;

    logic            stall_raw;
    logic            active;
    logic            insert;

    // Position from which an entry's result can be forwarded
    function automatic int ready_pos(input logic ld);
        return ld ? (1 + LOAD_LAT) : 1;
    endfunction

    assign en_a = id_use_rs && (id_rs != '0);
    assign en_b = id_use_rt && (id_rt != '0);

    // Youngest-match search: scan oldest to youngest so the lowest position wins
    always_comb begin
        src_a = '0;
        src_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int p = NSTG - 1; p >= 0; p--) begin
            if (en_a && e_valid[p] && e_wr[p] && (e_rd[p] == id_rs)) begin
                src_a = FW'(p + 1);
                haz_a = (p + 1) < ready_pos(e_load[p]);
            end
            if (en_b && e_valid[p] && e_wr[p] && (e_rd[p] == id_rt)) begin
                src_b = FW'(p + 1);
                haz_b = (p + 1) < ready_pos(e_load[p]);
            end
        end
    end

    // A hazard only matters for a real instruction in ID
    assign stall_raw = id_valid && (haz_a || haz_b);

    // Nothing advances during reset or a memory wait
    assign active = !reset && !mem_wait;

    // Priority: mem_wait > br_taken > stall > jump
    assign freeze      = !reset && mem_wait;
    assign flush_front = active && br_taken;
    assign stall       = active && !br_taken && stall_raw;
    assign flush_if_id = active && !br_taken && !stall_raw && id_valid && id_jump;

    // ID enters position 0 only when it is real, unstalled and not being flushed
    assign insert = id_valid && !br_taken && !stall_raw;

    // Shift the scoreboard and register forwarding selects; hold everything on freeze
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid <= '0;
            e_wr    <= '0;
            e_load  <= '0;
            for (int p = 0; p < NSTG; p++) begin
                e_rd[p] <= '0;
            end
            fwd_a   <= '0;
            fwd_b   <= '0;
        end else if (!mem_wait) begin
            for (int p = NSTG - 1; p >= 1; p--) begin
                // Entries younger than the taken branch land in 1..BR_STG and die
                e_valid[p] <= e_valid[p-1] && !(br_taken && (p <= BR_STG));
                e_wr[p]    <= e_wr[p-1];
                e_load[p]  <= e_load[p-1];
                e_rd[p]    <= e_rd[p-1];
            end
            e_valid[0] <= insert;
            e_wr[0]    <= id_wr;
            e_load[0]  <= id_load;
            e_rd[0]    <= id_rd;
            fwd_a      <= insert ? src_a : '0;
            fwd_b      <= insert ? src_b : '0;
        end
    end

    // Saturating event counters; stall and flush outputs are already gated by freeze
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((flush_front || flush_if_id) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic [4:0] id_rd = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic       id_wr = 1'b0;
    logic       id_load = 1'b0;
    logic       id_jump = 1'b0;
    logic       br_taken = 1'b0;
    logic       mem_wait = 1'b0;

    logic        a_stall, a_freeze, a_fif, a_ff;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [15:0] a_scnt, a_fcnt;

    logic        b_stall, b_freeze, b_fif, b_ff;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [15:0] b_scnt, b_fcnt;

    logic        c_stall, c_freeze, c_fif, c_ff;
    logic [1:0]  c_fwd_a, c_fwd_b;
    logic [1:0]  c_scnt, c_fcnt;

    int total = 0;
    int bad = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } fexp_t;
    fexp_t fq[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.RW(5), .NSTG(2), .LOAD_LAT(1), .BR_STG(1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_load(id_load),
        .id_jump(id_jump), .br_taken(br_taken), .mem_wait(mem_wait),
        .stall(a_stall), .freeze(a_freeze), .flush_if_id(a_fif), .flush_front(a_ff),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    hazard_scoreboard #(.RW(5), .NSTG(3), .LOAD_LAT(2), .BR_STG(1), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_load(id_load),
        .id_jump(id_jump), .br_taken(br_taken), .mem_wait(mem_wait),
        .stall(b_stall), .freeze(b_freeze), .flush_if_id(b_fif), .flush_front(b_ff),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    hazard_scoreboard #(.RW(5), .NSTG(2), .LOAD_LAT(1), .BR_STG(1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_load(id_load),
        .id_jump(id_jump), .br_taken(br_taken), .mem_wait(mem_wait),
        .stall(c_stall), .freeze(c_freeze), .flush_if_id(c_fif), .flush_front(c_ff),
        .fwd_a(c_fwd_a), .fwd_b(c_fwd_b), .stall_cnt(c_scnt), .flush_cnt(c_fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic wr, input logic ld, input logic jmp);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wr     = wr;
        id_load   = ld;
        id_jump   = jmp;
    endtask

    // One cycle: check combinational outputs, push expected fwd, clock, pop and compare
    task automatic tick(input int which, input logic br, input logic mw,
                        input logic es, input logic efz, input logic eif, input logic eff,
                        input logic [31:0] efa, input logic [31:0] efb, input string tag);
        fexp_t e;
        br_taken = br;
        mem_wait = mw;
        #1;
        chk({tag, ".stall"},  32'(which == 1 ? b_stall  : a_stall),  32'(es));
        chk({tag, ".freeze"}, 32'(which == 1 ? b_freeze : a_freeze), 32'(efz));
        chk({tag, ".fif"},    32'(which == 1 ? b_fif    : a_fif),    32'(eif));
        chk({tag, ".ff"},     32'(which == 1 ? b_ff     : a_ff),     32'(eff));
        e.a = efa;
        e.b = efb;
        fq.push_back(e);
        if (which == 0) begin
            if (es) exp_sc++;
            if (eff || eif) exp_fc++;
        end
        @(posedge clk);
        #1;
        e = fq.pop_front();
        chk({tag, ".fwd_a"}, 32'(which == 1 ? b_fwd_a : a_fwd_a), e.a);
        chk({tag, ".fwd_b"}, 32'(which == 1 ? b_fwd_b : a_fwd_b), e.b);
        if (which == 0) begin
            chk({tag, ".stall_cnt"}, 32'(a_scnt), 32'(exp_sc));
            chk({tag, ".flush_cnt"}, 32'(a_fcnt), 32'(exp_fc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ".rst_stall"}, 32'(a_stall), 0);
        chk({tag, ".rst_freeze"}, 32'(a_freeze), 0);
        chk({tag, ".rst_fif"}, 32'(a_fif), 0);
        chk({tag, ".rst_ff"}, 32'(a_ff), 0);
        chk({tag, ".rst_fwd"}, 32'({a_fwd_a, a_fwd_b}), 0);
        chk({tag, ".rst_cnt"}, 32'({a_scnt, a_fcnt}), 0);
        chk({tag, ".rst_c_cnt"}, 32'(c_scnt), 0);
        chk({tag, ".rst_b_stall"}, 32'(b_stall), 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 1'b0;
        mem_wait = 1'b0;
        reset = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
        fq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("init");

        // add r3,r1,r2 ; sub r4,r3,r1 -> forward rs from position 1, no stall
        drive(1, 1, 2, 3, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "fw_add");
        drive(1, 3, 1, 4, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 0, "fw_sub");
        idle(2);

        // lw r5 ; add r6,r5,r5 -> one stall, then forward from position 2
        drive(1, 1, 0, 5, 1, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "lu_lw");
        drive(1, 5, 5, 6, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 0, 0, 0, "lu_stall");
        tick(0, 0, 0, 0, 0, 0, 0, 2, 2, "lu_go");
        idle(2);

        // load into r0 then reader of r0 -> never stall, never forward
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_lw");
        drive(1, 0, 0, 9, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_use");
        idle(2);

        // add r7 then taken branch with add at position 0 -> add killed
        drive(1, 1, 2, 7, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "br_add");
        drive(1, 7, 1, 8, 1, 1, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 1, 0, 0, "br_flush");
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "br_after");
        idle(2);

        // add r9 ; lw r5 (reads r9) ; add r6,r5,r5 under a 3-cycle memory wait
        drive(1, 1, 2, 9, 1, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "mw_add");
        drive(1, 9, 0, 5, 1, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 0, "mw_lw");
        drive(1, 5, 5, 6, 1, 1, 1, 0, 0);
        tick(0, 0, 1, 0, 1, 0, 0, 1, 0, "mw_frz1");
        tick(0, 1, 1, 0, 1, 0, 0, 1, 0, "mw_frz2");
        tick(0, 0, 1, 0, 1, 0, 0, 1, 0, "mw_frz3");
        tick(0, 0, 0, 1, 0, 0, 0, 0, 0, "mw_stall");
        tick(0, 0, 0, 0, 0, 0, 0, 2, 2, "mw_go");
        idle(2);

        // lw r5 ; jr r5 -> jump flush waits for the stall to clear
        drive(1, 0, 0, 5, 0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "jr_lw");
        drive(1, 5, 0, 0, 1, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 0, 0, 0, 0, "jr_stall");
        tick(0, 0, 0, 0, 0, 1, 0, 2, 0, "jr_flush");
        idle(2);

        // reset asserted in the middle of a load-use stall
        drive(1, 0, 0, 5, 0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "mr_lw");
        drive(1, 5, 5, 6, 1, 1, 1, 0, 0);
        #1;
        chk("mr_pre_stall", 32'(a_stall), 1);
        do_reset("mr");

        // five load-use stalls: wide counter reaches 5, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 5, 0, 0, 1, 1, 0);
            tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_lw");
            drive(1, 5, 5, 6, 1, 1, 1, 0, 0);
            tick(0, 0, 0, 1, 0, 0, 0, 0, 0, "sat_stall");
            tick(0, 0, 0, 0, 0, 0, 0, 2, 2, "sat_go");
        end
        chk("sat_a_cnt", 32'(a_scnt), 5);
        chk("sat_c_cnt", 32'(c_scnt), 3);
        do_reset("b");

        // NSTG=3, LOAD_LAT=2: adjacent load-use stalls twice, then forwards from 3
        drive(1, 0, 0, 5, 0, 0, 1, 1, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, "l2_lw");
        drive(1, 5, 5, 6, 1, 1, 1, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0, 0, 0, "l2_stall1");
        tick(1, 0, 0, 1, 0, 0, 0, 0, 0, "l2_stall2");
        tick(1, 0, 0, 0, 0, 0, 0, 3, 3, "l2_go");
        chk("l2_cnt", 32'(b_scnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
